regfile_mp_sb: RTL and testbench

// - Parametrised multi-port integer register file with per-register pending (scoreboard) bits.
// - Sits in the ID stage of the pipelined CPU: NRD combinational read ports feed the operand muxes.
// - NWR write ports are driven by WB and a second writeback source (e.g. a late load or MUL return).
// - Pending bits let hazard detection stall on any in-flight producer, not only the load in EX.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_sb.sv | 56 +++++
 rtl/regfile_mp_sb.sv | 91 +++++++++
 tb/tb_regfile_mp_sb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants, address type and width helper for the
//            scoreboarded multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for a register count; never collapses to zero bits.
    function automatic int clog2_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AW_DEF = clog2_aw(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Per-register pending (scoreboard) bits with issue-set,
//            writeback-clear and flush.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 2,
    parameter int AW    = clog2_aw(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              busy_set_i,
    input  logic [AW-1:0]     busy_addr_i,
    input  logic              flush_i,
    output logic [NREGS-1:0]  pending_o
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_pending_nxt;

    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int r = 1; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == AW'(r)))
                    w_clr[r] = 1'b1;
            end
            if (busy_set_i && (busy_addr_i == AW'(r)))
                w_set[r] = 1'b1;
        end
        // Issue of a new producer beats both flush and writeback clear.
        w_pending_nxt = (flush_i ? '0 : (r_pending & ~w_clr)) | w_set;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_pending <= '0;
        else
            r_pending <= w_pending_nxt;
    end

    assign pending_o = r_pending;

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Purpose  : NRD-read / NWR-write register file with scoreboard pending bits.
//            Optional write-to-read forwarding under macro REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = clog2_aw(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                busy_set_i,
    input  logic [AW-1:0]       busy_addr_i,
    input  logic                flush_i,
    output logic                busy_any_o
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_pending;

    // Ascending port loop: the last non-blocking write (highest index) wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREGS; r++)
                r_regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0))
                    r_regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    regfile_sb #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .busy_set_i  (busy_set_i),
        .busy_addr_i (busy_addr_i),
        .flush_i     (flush_i),
        .pending_o   (w_pending)
    );

    assign busy_any_o = |w_pending;

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_busy;

            assign w_addr = rs_addr_i[k*AW +: AW];

            always_comb begin
                w_data = (w_addr == '0) ? '0 : r_regs[w_addr];
                w_busy = w_pending[w_addr];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && (w_addr != '0) && (wr_addr_i[j*AW +: AW] == w_addr)) begin
                        w_data = wr_data_i[j*XLEN +: XLEN];
                        w_busy = busy_set_i && (busy_addr_i == w_addr);
                    end
                end
`endif
            end

            assign rs_data_o[k*XLEN +: XLEN] = w_data;
            assign rs_busy_o[k]              = w_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_sb
// Purpose  : Directed self-checking bench for regfile_mp_sb (2R/2W, 32x32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [2*AW-1:0] rs_addr_i;
    logic [63:0]     rs_data_o;
    logic [1:0]      rs_busy_o;
    logic [1:0]      wr_en_i;
    logic [2*AW-1:0] wr_addr_i;
    logic [63:0]     wr_data_i;
    logic            busy_set_i;
    logic [AW-1:0]   busy_addr_i;
    logic            flush_i;
    logic            busy_any_o;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_mp_sb #(
        .XLEN  (XLEN),
        .NREGS (32),
        .NRD   (2),
        .NWR   (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rs_addr_i   (rs_addr_i),
        .rs_data_o   (rs_data_o),
        .rs_busy_o   (rs_busy_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .busy_set_i  (busy_set_i),
        .busy_addr_i (busy_addr_i),
        .flush_i     (flush_i),
        .busy_any_o  (busy_any_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en_i    = 2'b00;
        busy_set_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0;
        rs_addr_i = '0; wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
        busy_set_i = 1'b0; busy_addr_i = '0; flush_i = 1'b0;
        #1;
        check("reset_data", rs_data_o[31:0], 32'h0);
        check("reset_busy_any", {31'd0, busy_any_o}, 32'h0);
        tick(); tick();
        rst_i = 1'b1;

        // Asynchronous reset pulse between edges
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd5}; wr_data_i = {32'h0, 32'hDEADBEEF};
        busy_set_i = 1'b1; busy_addr_i = 5'd6;
        tick(); idle();
        rs_addr_i = {5'd6, 5'd5};
        #1;
        check("r5_written", rs_data_o[31:0], 32'hDEADBEEF);
        check("r6_pending", {31'd0, rs_busy_o[1]}, 32'h1);
        rst_i = 1'b0;
        #1;
        check("rstpulse_data", rs_data_o[31:0], 32'h0);
        check("rstpulse_busy_any", {31'd0, busy_any_o}, 32'h0);
        rst_i = 1'b1;
        tick();

        // x0 ignores writes and busy_set
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd0}; wr_data_i = {32'h0, 32'h1234};
        busy_set_i = 1'b1; busy_addr_i = 5'd0;
        rs_addr_i = {5'd0, 5'd0};
        #1;
        check("x0_same_cycle", rs_data_o[31:0], 32'h0);
        tick(); idle();
        #1;
        check("x0_data", rs_data_o[63:32], 32'h0);
        check("x0_busy", {30'd0, rs_busy_o}, 32'h0);
        check("x0_busy_any", {31'd0, busy_any_o}, 32'h0);

        // Write collision on r7: port 1 wins
        wr_en_i = 2'b11; wr_addr_i = {5'd7, 5'd7}; wr_data_i = {32'h22, 32'h11};
        rs_addr_i = {5'd7, 5'd7};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("coll_bypass", rs_data_o[31:0], 32'h22);
`else
        check("coll_old", rs_data_o[31:0], 32'h0);
`endif
        tick(); idle();
        #1;
        check("coll_p0", rs_data_o[31:0], 32'h22);
        check("coll_p1", rs_data_o[63:32], 32'h22);

        // Scoreboard: set r3, hold pending, clear by writeback
        busy_set_i = 1'b1; busy_addr_i = 5'd3;
        rs_addr_i = {5'd3, 5'd3};
        tick(); idle();
        for (int c = 1; c <= 3; c++) begin
            check("sb_busy_p0", {31'd0, rs_busy_o[0]}, 32'h1);
            check("sb_busy_p1", {31'd0, rs_busy_o[1]}, 32'h1);
            if (c < 3) tick();
        end
        check("sb_busy_any", {31'd0, busy_any_o}, 32'h1);
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd3}; wr_data_i = {32'h0, 32'h33};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("sb_wb_fwd_busy", {31'd0, rs_busy_o[0]}, 32'h0);
        check("sb_wb_fwd_data", rs_data_o[31:0], 32'h33);
`else
        check("sb_wb_old_busy", {31'd0, rs_busy_o[0]}, 32'h1);
        check("sb_wb_old_data", rs_data_o[31:0], 32'h0);
`endif
        tick(); idle();
        check("sb_cleared", {31'd0, rs_busy_o[0]}, 32'h0);
        check("sb_data", rs_data_o[63:32], 32'h33);
        check("sb_any_clear", {31'd0, busy_any_o}, 32'h0);

        // Set and write r3 in the same cycle: set wins
        busy_set_i = 1'b1; busy_addr_i = 5'd3;
        wr_en_i = 2'b10; wr_addr_i = {5'd3, 5'd0}; wr_data_i = {32'h44, 32'h0};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("sw_fwd_busy", {31'd0, rs_busy_o[0]}, 32'h1);
        check("sw_fwd_data", rs_data_o[31:0], 32'h44);
`else
        check("sw_old_busy", {31'd0, rs_busy_o[0]}, 32'h0);
        check("sw_old_data", rs_data_o[31:0], 32'h33);
`endif
        tick(); idle();
        check("sw_busy", {31'd0, rs_busy_o[0]}, 32'h1);
        check("sw_data", rs_data_o[31:0], 32'h44);
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd3}; wr_data_i = {32'h0, 32'h44};
        tick(); idle();
        check("sw_drain", {31'd0, busy_any_o}, 32'h0);

        // Flush with concurrent issue
        busy_set_i = 1'b1; busy_addr_i = 5'd4;
        tick();
        busy_addr_i = 5'd9;
        tick(); idle();
        rs_addr_i = {5'd9, 5'd4};
        #1;
        check("fl_r4_pend", {31'd0, rs_busy_o[0]}, 32'h1);
        check("fl_r9_pend", {31'd0, rs_busy_o[1]}, 32'h1);
        flush_i = 1'b1; busy_set_i = 1'b1; busy_addr_i = 5'd12;
        tick(); idle();
        check("fl_r4_clr", {31'd0, rs_busy_o[0]}, 32'h0);
        check("fl_r9_clr", {31'd0, rs_busy_o[1]}, 32'h0);
        check("fl_any", {31'd0, busy_any_o}, 32'h1);
        rs_addr_i = {5'd9, 5'd12};
        #1;
        check("fl_r12_pend", {31'd0, rs_busy_o[0]}, 32'h1);
        flush_i = 1'b1;
        tick(); idle();
        check("fl_all_clr", {31'd0, busy_any_o}, 32'h0);

        // Bypass: r8 pending with old value, then written with 0xCAFE
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd8}; wr_data_i = {32'h0, 32'h1111};
        busy_set_i = 1'b1; busy_addr_i = 5'd8;
        tick(); idle();
        rs_addr_i = {5'd8, 5'd0};
        #1;
        check("bp_pre_busy", {31'd0, rs_busy_o[1]}, 32'h1);
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd8}; wr_data_i = {32'h0, 32'hCAFE};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bp_fwd_data", rs_data_o[63:32], 32'hCAFE);
        check("bp_fwd_busy", {31'd0, rs_busy_o[1]}, 32'h0);
`else
        check("bp_old_data", rs_data_o[63:32], 32'h1111);
        check("bp_old_busy", {31'd0, rs_busy_o[1]}, 32'h1);
`endif
        tick(); idle();
        check("bp_next_data", rs_data_o[63:32], 32'hCAFE);
        check("bp_next_busy", {31'd0, rs_busy_o[1]}, 32'h0);

        // Reset across an edge discards an in-flight write and pending set
        @(negedge clk_i);
        wr_en_i = 2'b10; wr_addr_i = {5'd5, 5'd0}; wr_data_i = {32'h55, 32'h0};
        busy_set_i = 1'b1; busy_addr_i = 5'd5;
        rst_i = 1'b0;
        tick(); idle();
        rst_i = 1'b1;
        rs_addr_i = {5'd8, 5'd5};
        #1;
        check("mid_rst_r5", rs_data_o[31:0], 32'h0);
        check("mid_rst_r8", rs_data_o[63:32], 32'h0);
        check("mid_rst_any", {31'd0, busy_any_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
